// File: rtl/bit_serial_adder.sv
// bit_serial_adder: sequences one full-adder cell over WIDTH clock cycles.
// The operands and carry-in are latched when a start is accepted.
// One bit pair, LSB first, is added per cycle.
// The carry is held between cycles, and each sum bit is shifted into the result from the top.
// Optional feature: define BSA_OVF_EN to add the ovf port (signed overflow of the final add).
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BSA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic            carry_r;
  logic [CW-1:0]   count_r;
  logic            armed_r;
  logic            accept_s;
  logic            last_s;
  logic [1:0]      fa_s;

  // Full adder built from two half adders plus an OR; returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic h1_sum;
    logic h1_carry;
    logic h2_sum;
    logic h2_carry;
    h1_sum   = x ^ y;
    h1_carry = x & y;
    h2_sum   = h1_sum ^ c;
    h2_carry = h1_sum & c;
    return {h1_carry | h2_carry, h2_sum};
  endfunction

  assign fa_s   = full_add(opa_r[0], opb_r[0], carry_r);
  assign last_s = (count_r == LAST_BIT);

  // Next-state logic; a start is accepted only from IDLE or DONE, and never on the first edge after reset.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && armed_r) begin
          accept_s = 1'b1;
          state_s  = SHIFT;
        end else begin
          state_s  = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        if (start && armed_r) begin
          accept_s = 1'b1;
          state_s  = SHIFT;
        end else begin
          state_s  = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, plus registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == SHIFT);
      done    <= (state_s == DONE);
      armed_r <= 1'b1;
    end
  end

  // Operand shift registers, running carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_r   <= '0;
      opb_r   <= '0;
      carry_r <= 1'b0;
      count_r <= '0;
    end else if (accept_s) begin
      opa_r   <= a;
      opb_r   <= b;
      carry_r <= cin;
      count_r <= '0;
    end else if (state_r == SHIFT) begin
      opa_r   <= opa_r >> 1;
      opb_r   <= opb_r >> 1;
      carry_r <= fa_s[1];
      count_r <= count_r + CW'(1);
    end
  end

  // Result register: sum bits enter at the MSB, and cout is captured on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (state_r == SHIFT) begin
      sum <= {fa_s[0], sum[WIDTH-1:1]};
      if (last_s) begin
        cout <= fa_s[1];
      end
    end
  end

`ifdef BSA_OVF_EN
  // Signed overflow is the carry into the MSB XOR the carry out of it; it is cleared by a new add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept_s) begin
      ovf <= 1'b0;
    end else if ((state_r == SHIFT) && last_s) begin
      ovf <= carry_r ^ fa_s[1];
    end
  end
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder (WIDTH=8).
// A vector table covers plain adds.
// Hand sequences cover back-to-back adds, a start while busy, and a reset in the middle of an add.
module tb_bit_serial_adder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cin   = 1'b0;
  logic [7:0] a     = 8'h00;
  logic [7:0] b     = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef BSA_OVF_EN
  logic       ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[10];

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef BSA_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Presents operands and a one-cycle start, then returns #1 after the accepting edge.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts busy cycles until done is seen, with a bounded wait.
  task automatic wait_done(output int busy_cnt, output bit got);
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bc;
    bit got;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[8] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0};
    vecs[9] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};

    // Reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven adds
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(bc, got);
      check($sformatf("got_done[%0d]", i), got, 1);
      check($sformatf("busy_cycles[%0d]", i), bc, 8);
      check($sformatf("sum[%0d]", i), sum, vecs[i].s);
      check($sformatf("cout[%0d]", i), cout, vecs[i].co);
`ifdef BSA_OVF_EN
      check($sformatf("ovf[%0d]", i), ovf, vecs[i].ov);
`endif
      @(posedge clk);
      #1;
      check($sformatf("done_pulse[%0d]", i), done, 0);
      check($sformatf("sum_hold[%0d]", i), sum, vecs[i].s);
    end

    // Back-to-back: start held through DONE; operand changes while busy are ignored
    @(negedge clk);
    a     = 8'h03;
    b     = 8'h04;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h10;
    b = 8'h20;
    wait_done(bc, got);
    check("b2b_got1", got, 1);
    check("b2b_busy1", bc, 8);
    check("b2b_sum1", sum, 8'h07);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_busy_rise", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done(bc, got);
    check("b2b_got2", got, 1);
    check("b2b_busy2", bc, 8);
    check("b2b_sum2", sum, 8'h30);

    // start while busy is ignored
    launch(8'h21, 8'h11, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(bc, got);
    check("ign_got", got, 1);
    check("ign_busy_rest", bc, 5);
    check("ign_sum", sum, 8'h32);
    check("ign_cout", cout, 0);
    @(posedge clk);
    #1;
    check("ign_no_restart", busy, 0);

    // Reset during the 4th SHIFT cycle
    launch(8'h55, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_sum", sum, 0);
    check("arst_cout", cout, 0);
    got = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    check("arst_no_done", got, 0);
    @(negedge clk);
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    rst_n = 1'b1;
    #1;
    start = 1'b0;
    check("rel_start_ignored", busy, 0);
    launch(8'h12, 8'h34, 1'b0);
    wait_done(bc, got);
    check("post_rst_got", got, 1);
    check("post_rst_sum", sum, 8'h46);
    check("post_rst_cout", cout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
